detect_full_reg: RTL and testbench

Registered full-nibble detector: a 12-bit input word is treated as three 4-bit slots, and each slot reports "full" when all four of its bits are 1. The per-slot flags are packed into a 3-bit status vector and registered on the clock edge. The block sits between a 12-bit status/occupancy word producer and downstream control logic that needs a compact, glitch-free "which slots are full" indication.

---
 rtl/detect_full_reg.sv | 18 +
 tb/tb_detect_full_reg.sv | 99 +++++++++
 2 files changed

// File: rtl/detect_full_reg.sv
// detect_full_reg: registered per-nibble all-ones detector for a 12-bit word
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset, clears f
//   ain   - input word, slot 2 = ain[11:8], slot 1 = ain[7:4], slot 0 = ain[3:0]
//   f     - registered flags, f[i] set when slot i was all ones at the last edge
module detect_full_reg (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [11:0] ain,
   output logic [2:0]  f
);
   logic [2:0] full;
   always_comb full = {&ain[11:8], &ain[7:4], &ain[3:0]};
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) f <= 3'b000;
      else        f <= full;
endmodule

// File: tb/tb_detect_full_reg.sv
// tb_detect_full_reg: randomized self-checking bench for detect_full_reg
module tb_detect_full_reg;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [11:0] ain = '0;
   logic [2:0]  f;
   int          errors = 0;
   int          checks = 0;

   detect_full_reg dut (.clk(clk), .rst_n(rst_n), .ain(ain), .f(f));

   always #5 clk = ~clk;

   function automatic logic [2:0] model(input logic [11:0] a);
      logic [2:0] r;
      for (int i = 0; i < 3; i++) r[i] = ((int'(a) >> (4 * i)) % 16) == 15;
      return r;
   endfunction

   task automatic chk(input string tag, input logic [2:0] got, input logic [2:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%b expected=%b at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step(input string tag, input logic [11:0] a);
      @(negedge clk);
      ain = a;
      @(posedge clk);
      #1;
      chk(tag, f, model(a));
   endtask

   initial begin
      logic [11:0] a;
      logic [2:0]  exp;
      logic        in_rst;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_init", f, 3'b000);
      @(negedge clk);
      rst_n = 1'b1;
      step("preload_all1", 12'hFFF);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("reset_async", f, 3'b000);
      repeat (2) begin
         @(posedge clk);
         #1;
         chk("reset_hold", f, 3'b000);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("reset_release_pre", f, 3'b000);
      @(posedge clk);
      #1;
      chk("reset_release", f, 3'b111);
      step("slot0", 12'h00F);
      step("slot1", 12'h0F0);
      step("slot2", 12'hF00);
      step("mix_ff0", 12'hFF0);
      step("mix_f07", 12'hF07);
      step("mix_dff", 12'hDFF);
      step("mix_eb2", 12'hEB2);
      for (int k = 0; k < 12; k++) step($sformatf("near_full_b%0d", k), 12'hFFF ^ (12'h001 << k));
      step("all_ones", 12'hFFF);
      step("all_zeros", 12'h000);
      step("glitch_base", 12'h00F);
      #2 ain = 12'h000;
      #1;
      chk("glitch_mid", f, 3'b001);
      #1 ain = 12'h00F;
      @(posedge clk);
      #1;
      chk("glitch_after", f, 3'b001);
      for (int n = 0; n < 1000; n++) begin
         @(negedge clk);
         a = 12'($urandom);
         if ($urandom_range(0, 3) == 0) a[4 * $urandom_range(0, 2) +: 4] = 4'hF;
         ain = a;
         in_rst = ($urandom_range(0, 19) == 0);
         if (in_rst) begin
            rst_n = 1'b0;
            #1;
            chk("rand_reset_async", f, 3'b000);
         end else rst_n = 1'b1;
         exp = in_rst ? 3'b000 : model(a);
         @(posedge clk);
         #1;
         chk("rand", f, exp);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
